adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_ctrl_if.sv | 28 ++
 rtl/adder_seq_ctrl.sv | 117 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Request/response bundle between a requester and the multi-word add/sub sequencer.
// The requester drives start/sub/a/b; the sequencer returns status and the result.
interface adder_seq_ctrl_if #(
    parameter int NWORDS = 4
);
    localparam int W = 16 * NWORDS;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout, ovf
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-word add/subtract sequencer: one 16-bit slice per cycle through a shared adder16,
// least significant slice first, with the carry held in a register between slices.
module adder16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = 17'(x) + 17'(y) + 17'(cin);
endmodule

module adder_seq_ctrl #(
    parameter int NWORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    adder_seq_ctrl_if.slave bus
);
    localparam int W  = 16 * NWORDS;
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   areg;
    logic [W-1:0]   breg;
    logic [W-1:0]   result_q;
    logic           cout_q;
    logic           ovf_q;
    logic [15:0]    add_x;
    logic [15:0]    add_y;
    logic [15:0]    add_sum;
    logic           add_cout;

    // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeds the +1.
    assign add_x = areg[{idx, 4'b0000} +: 16];
    assign add_y = breg[{idx, 4'b0000} +: 16];

    adder16 u_adder16 (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (idx == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            areg     <= '0;
            breg     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        areg     <= bus.a;
                        breg     <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub;
                        idx      <= '0;
                        result_q <= '0;
                    end
                end
                RUN: begin
                    result_q[{idx, 4'b0000} +: 16] <= add_sum;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout_q <= add_cout;
                        ovf_q  <= (areg[W-1] == breg[W-1]) && (add_sum[15] != areg[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed and random add/sub operations against
// a whole-word arithmetic model, plus protocol, timing and mid-operation reset scenarios.
module tb_adder_seq_ctrl;
    localparam int NWORDS = 4;
    localparam int W      = 16 * NWORDS;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_seq_ctrl_if #(.NWORDS(NWORDS)) bus ();

    adder_seq_ctrl #(.NWORDS(NWORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width arithmetic; subtract carry means "no borrow", i.e. a >= b unsigned.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] r, output logic c, output logic o);
        logic [W:0] wide;
        if (sub) begin
            r = a - b;
            c = (a >= b);
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[W-1:0];
            c = wide[W];
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Follows one accepted operation cycle by cycle: NWORDS busy cycles, one done, then ready.
    task automatic watch(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        logic         eready, ebusy, edone;
        model(a, b, sub, er, ec, eo);
        for (int k = 1; k <= NWORDS + 2; k++) begin
            @(negedge clk);
            eready = (k == NWORDS + 2);
            ebusy  = (k <= NWORDS);
            edone  = (k == NWORDS + 1);
            checks++;
            if ({bus.ready, bus.busy, bus.done} !== {eready, ebusy, edone}) begin
                errors++;
                $display("FAIL %s status cycle %0d: ready/busy/done=%b%b%b expected %b%b%b",
                         name, k, bus.ready, bus.busy, bus.done, eready, ebusy, edone);
            end
            if (k >= NWORDS + 1) begin
                checks++;
                if ({bus.result, bus.cout, bus.ovf} !== {er, ec, eo}) begin
                    errors++;
                    $display("FAIL %s result cycle %0d: result=%h cout=%b ovf=%b expected %h %b %b",
                             name, k, bus.result, bus.cout, bus.ovf, er, ec, eo);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.ovf} !==
            {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b result=%h cout=%b ovf=%b expected 1 0 0 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_directed;
        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        watch("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        watch("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        issue(64'h5, 64'h7, 1'b1);
        watch("sub_borrow", 64'h5, 64'h7, 1'b1);
        issue(64'h7, 64'h5, 1'b1);
        watch("sub_noborrow", 64'h7, 64'h5, 1'b1);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        watch("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b1);
        watch("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b1);
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic         s;
        for (int n = 0; n < 40; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            if (n % 8 == 3) b = ~a;
            if (n % 8 == 5) b = a;
            issue(a, b, s);
            watch("random", a, b, s);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a1, b1, a2, b2;
        a1 = 64'h1234_5678_9ABC_DEF0;
        b1 = 64'h0FED_CBA9_8765_4321;
        a2 = 64'hDEAD_BEEF_0000_FFFF;
        b2 = 64'h0000_0001_FFFF_0001;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a1;
        bus.b = b1;
        bus.sub = 1'b0;
        @(posedge clk);
        #1;
        bus.a = a2;
        bus.b = b2;
        bus.sub = 1'b1;
        watch("held_first", a1, b1, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        watch("held_second", a2, b2, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        int dones;
        issue(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.ovf} !==
            {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_state: ready=%b busy=%b done=%b result=%h cout=%b ovf=%b expected 1 0 0 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.ovf);
        end
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: done pulses=%0d expected 0", dones);
        end
        issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        watch("after_reset", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
